// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding,
// the default frame sync marker and the fixed header length.
package loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    IDX_LO,
    IDX_HI,
    CNT_LO,
    CNT_HI,
    DAT_LO,
    DAT_HI,
    WRITE,
    CHK
  } loader_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Header bytes following sync: index lo/hi, count lo/hi.
  localparam int HDR_LEN = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and CPU program-download port of the loader.
// master: the loader side; slave: the stream source / CPU side.
interface program_loader_if #(
  parameter int INDEX_W = 32
);

  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic               download_program;
  logic [INDEX_W-1:0] instruction_index;
  logic [15:0]        program_in;
  logic               program_we;
  logic               done;
  logic               error;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, download_program, instruction_index, program_in,
           program_we, done, error
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, download_program, instruction_index, program_in,
           program_we, done, error
  );

endinterface

// File: rtl/program_loader.sv
// Program loader: parses SYNC, index, count and little-endian halfword
// payload from a byte stream and writes each halfword to the CPU
// download port, holding the CPU in download mode while the frame loads.
// Optional trailing XOR checksum enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         INDEX_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.master  bus
);

  loader_state_t state, state_nxt;
  logic [15:0]   idx_q;
  logic [15:0]   cnt_q;
  logic [7:0]    lo_q;
  logic [7:0]    hi_q;
  logic          accept;
  logic          finish;
  logic          end_p0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q;
  logic          fail;
`endif

  assign bus.byte_ready = !reset && (state != WRITE);
  assign accept         = bus.byte_valid && bus.byte_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; finish flags a successfully completed frame
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    fail      = 1'b0;
`endif
    case (state)
      IDLE:   if (accept && bus.byte_in == SYNC_BYTE) state_nxt = IDX_LO;
      IDX_LO: if (accept) state_nxt = IDX_HI;
      IDX_HI: if (accept) state_nxt = CNT_LO;
      CNT_LO: if (accept) state_nxt = CNT_HI;
      CNT_HI: begin
        if (accept) begin
          if ({bus.byte_in, cnt_q[7:0]} == 16'd0) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = DAT_LO;
          end
        end
      end
      DAT_LO: if (accept) state_nxt = DAT_HI;
      DAT_HI: if (accept) state_nxt = WRITE;
      WRITE: begin
        if (cnt_q != 16'd1) begin
          state_nxt = DAT_LO;
        end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = IDLE;
          finish    = 1'b1;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_nxt = IDLE;
          if (bus.byte_in == csum_q) finish = 1'b1;
          else                       fail   = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Frame fields: header capture, payload bytes, index/count stepping
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      cnt_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else if (state == WRITE) begin
      idx_q <= idx_q + 16'd1;
      cnt_q <= cnt_q - 16'd1;
    end else if (accept) begin
      case (state)
        IDX_LO:  idx_q[7:0]  <= bus.byte_in;
        IDX_HI:  idx_q[15:8] <= bus.byte_in;
        CNT_LO:  cnt_q[7:0]  <= bus.byte_in;
        CNT_HI:  cnt_q[15:8] <= bus.byte_in;
        DAT_LO:  lo_q        <= bus.byte_in;
        DAT_HI:  hi_q        <= bus.byte_in;
        default: ;
      endcase
    end
  end

  // Registered CPU port: write one cycle after WRITE, release one cycle after finish
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.download_program  <= 1'b0;
      bus.instruction_index <= '0;
      bus.program_in        <= '0;
      bus.program_we        <= 1'b0;
      bus.done              <= 1'b0;
      end_p0                <= 1'b0;
    end else begin
      bus.program_we <= (state == WRITE);
      end_p0         <= finish;
      bus.done       <= end_p0;
      if (state == WRITE) begin
        bus.download_program  <= 1'b1;
        bus.program_in        <= {hi_q, lo_q};
        bus.instruction_index <= INDEX_W'(idx_q);
      end else if (end_p0) begin
        bus.download_program  <= 1'b0;
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running XOR of header and payload bytes; sticky error on mismatch
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q    <= '0;
      bus.error <= 1'b0;
    end else if (accept) begin
      if (state == IDLE && bus.byte_in == SYNC_BYTE) begin
        csum_q    <= '0;
        bus.error <= 1'b0;
      end else if (state inside {IDX_LO, IDX_HI, CNT_LO, CNT_HI, DAT_LO, DAT_HI}) begin
        csum_q    <= csum_q ^ bus.byte_in;
      end
      if (fail) bus.error <= 1'b1;
    end
  end
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard.
`timescale 1ns/1ps
module tb_program_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  program_loader_if #(.INDEX_W(32)) bus ();

  program_loader #(.SYNC_BYTE(8'hA5), .INDEX_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int we_cnt = 0;
  bit dl_seen = 0;
  bit prev_rdy_low = 0;
  logic [47:0] sb[$];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  bit corrupt_ck = 0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gap(input int gmax);
    return (gmax == 0) ? 0 : int'($urandom_range(gmax, 0));
  endfunction

  // Output monitor: scoreboard pop on each write, bubble and done checks
  always @(negedge clk) begin
    logic [47:0] e;
    if (!reset) begin
      if (bus.program_we || prev_rdy_low)
        check("ready_bubble", bus.program_we, prev_rdy_low);
      if (bus.program_we) begin
        we_cnt++;
        check("sb_nonempty_on_we", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("index", bus.instruction_index, e[47:16]);
          check("data", bus.program_in, e[15:0]);
          check("dl_during_we", bus.download_program, 1);
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("dl_at_done", bus.download_program, 0);
      end
      if (bus.download_program) dl_seen = 1;
    end
    prev_rdy_low = !reset && !bus.byte_ready;
  end

  task automatic send(input logic [7:0] b, input int g);
    int n;
    bit acc;
    n = 0;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    do begin
      acc = bus.byte_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", acc, 1);
    bus.byte_valid = 1'b0;
    repeat (g) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] idx, input logic [15:0] words[$], input int gmax);
    logic [7:0]  ck;
    logic [15:0] cnt;
    logic [15:0] a;
    cnt = 16'(words.size());
    ck = idx[7:0] ^ idx[15:8] ^ cnt[7:0] ^ cnt[15:8];
    send(8'hA5, gap(gmax));
    send(idx[7:0], gap(gmax));
    send(idx[15:8], gap(gmax));
    send(cnt[7:0], gap(gmax));
    send(cnt[15:8], gap(gmax));
    for (int i = 0; i < words.size(); i++) begin
      a = idx + 16'(i);
      send(words[i][7:0], gap(gmax));
      sb.push_back({32'(a), words[i]});
      send(words[i][15:8], gap(gmax));
      ck = ck ^ words[i][7:0] ^ words[i][15:8];
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (words.size() != 0) send(corrupt_ck ? (ck ^ 8'h10) : ck, 0);
`endif
  endtask

  task automatic wait_done(input int exp_done);
    int n;
    n = 0;
    while (done_cnt < exp_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_count", done_cnt, exp_done);
    check("sb_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
    check("dl_after_done", bus.download_program, 0);
    check("done_count_stable", done_cnt, exp_done);
  endtask

  initial begin
    logic [15:0] w[$];
    int we0;
    int n;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_byte_ready", bus.byte_ready, 0);
    check("rst_download", bus.download_program, 0);
    check("rst_index", bus.instruction_index, 0);
    check("rst_program_in", bus.program_in, 0);
    check("rst_we", bus.program_we, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.byte_ready, 1);

    // Two-word load at index 10
    w = '{16'h2021, 16'h2005};
    send_frame(16'h000A, w, 0);
    wait_done(1);
    check("we_count_t1", we_cnt, 2);

    // Junk bytes before sync are discarded
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h13, 0);
    send_frame(16'h000A, w, 0);
    wait_done(2);
    check("we_count_t2", we_cnt, 4);

    // Random valid gaps
    send_frame(16'h000A, w, 5);
    wait_done(3);
    check("we_count_t3", we_cnt, 6);

    // Index wraps from 0xFFFF to 0x0000
    w = '{16'h1234, 16'hABCD};
    send_frame(16'hFFFF, w, 1);
    wait_done(4);

    // Count zero: done only
    dl_seen = 0;
    we0 = we_cnt;
    w = {};
    send_frame(16'h0000, w, 0);
    wait_done(5);
    check("cnt0_dl_never", dl_seen, 0);
    check("cnt0_no_we", we_cnt, we0);

    // Reset after first write of a 3-word frame
    we0 = we_cnt;
    send(8'hA5, 0); send(8'h20, 0); send(8'h00, 0); send(8'h03, 0); send(8'h00, 0);
    send(8'h11, 0);
    sb.push_back({32'h0000_0020, 16'h5511});
    send(8'h55, 0);
    n = 0;
    while (we_cnt == we0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_first_we", we_cnt, we0 + 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_download", bus.download_program, 0);
    check("mid_rst_we", bus.program_we, 0);
    check("mid_rst_index", bus.instruction_index, 0);
    check("mid_rst_data", bus.program_in, 0);
    check("mid_rst_ready", bus.byte_ready, 0);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    w = '{16'h1111, 16'h2222, 16'h3333};
    send_frame(16'h0020, w, 2);
    wait_done(6);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Corrupted checksum: error, CPU kept in download mode, no done
    corrupt_ck = 1;
    w = '{16'hBEEF, 16'h0102};
    send_frame(16'h0100, w, 0);
    repeat (4) @(negedge clk);
    check("ck_bad_error", bus.error, 1);
    check("ck_bad_dl_held", bus.download_program, 1);
    check("ck_bad_no_done", done_cnt, 6);
    corrupt_ck = 0;
    send_frame(16'h0100, w, 0);
    wait_done(7);
    check("ck_good_error_clear", bus.error, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
